// File: rtl/scale_weight_capture_pkg.sv
// Shared types and widths for the scale weight capture front-end.
// Widths match the weight/height inputs of smart_scales_system.
package scale_pkg;

    localparam int WEIGHT_W = 9;
    localparam int HEIGHT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/scale_weight_capture_if.sv
// Sample/measurement bus between the load-cell source, the capture block and its consumer.
// The tare strobe exists only when SCALE_TARE_EN is defined.
interface scale_weight_capture_if;
    import scale_pkg::*;

    logic                sample_valid;
    logic [WEIGHT_W-1:0] raw_weight;
    logic [HEIGHT_W-1:0] height_in;
    logic                meas_ack;
`ifdef SCALE_TARE_EN
    logic                tare;
`endif
    logic [WEIGHT_W-1:0] weight;
    logic [HEIGHT_W-1:0] height;
    logic                meas_valid;
    logic                busy;

    modport master (
`ifdef SCALE_TARE_EN
        output tare,
`endif
        output sample_valid, raw_weight, height_in, meas_ack,
        input  weight, height, meas_valid, busy
    );

    modport slave (
`ifdef SCALE_TARE_EN
        input  tare,
`endif
        input  sample_valid, raw_weight, height_in, meas_ack,
        output weight, height, meas_valid, busy
    );

endinterface

// File: rtl/scale_weight_capture_settle_detector.sv
// Tracks the reference sample and run of in-tolerance samples; flags empty platform,
// in-tolerance samples and the sample that completes settling.
module scale_settle_detector
    import scale_pkg::*;
#(
    parameter int TOL        = 2,
    parameter int SETTLE_CNT = 4,
    parameter int MIN_LOAD   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  state_t              i_state,
    input  logic                i_sample_valid,
    input  logic [WEIGHT_W-1:0] i_raw,
    output logic                o_in_tol,
    output logic                o_empty,
    output logic                o_settled
);

    localparam int CNT_W = $clog2(SETTLE_CNT + 1);
    localparam logic [WEIGHT_W:0]   TOL_D     = (WEIGHT_W+1)'(TOL);
    localparam logic [WEIGHT_W:0]   ONE_D     = (WEIGHT_W+1)'(1);
    localparam logic [WEIGHT_W-1:0] MIN_D     = WEIGHT_W'(MIN_LOAD);
    localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(SETTLE_CNT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

    logic [WEIGHT_W-1:0] r_ref;
    logic [CNT_W-1:0]    r_stable_cnt;
    logic [WEIGHT_W:0]   w_diff;
    logic [WEIGHT_W:0]   w_abs_diff;
    logic                w_take;

    // 10-bit two's-complement difference; magnitude never exceeds 511.
    assign w_diff     = {1'b0, i_raw} - {1'b0, r_ref};
    assign w_abs_diff = w_diff[WEIGHT_W] ? (~w_diff + ONE_D) : w_diff;

    assign o_in_tol  = (w_abs_diff <= TOL_D);
    assign o_empty   = (i_raw < MIN_D);
    assign o_settled = (i_state == SETTLE) && i_sample_valid && !o_empty &&
                       o_in_tol && (r_stable_cnt == LAST_CNT);

    assign w_take = i_sample_valid && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref        <= '0;
            r_stable_cnt <= '0;
        end else if (w_take) begin
            case (i_state)
                IDLE: begin
                    r_ref        <= i_raw;
                    r_stable_cnt <= '0;
                end
                SETTLE: begin
                    if (o_in_tol) begin
                        r_stable_cnt <= r_stable_cnt + CNT_ONE;
                    end else begin
                        r_ref        <= i_raw;
                        r_stable_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (!o_in_tol) begin
                        r_ref        <= i_raw;
                        r_stable_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/scale_weight_capture.sv
// Waits for a settled load, averages NSAMP stable samples and holds one weight/height
// pair under a valid/ack handshake. Optional tare offset: SCALE_TARE_EN.
module scale_weight_capture
    import scale_pkg::*;
#(
    parameter int NSAMP      = 8,
    parameter int TOL        = 2,
    parameter int SETTLE_CNT = 4,
    parameter int MIN_LOAD   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scale_weight_capture_if.slave  bus
);

    localparam int LOG2N = $clog2(NSAMP);
    localparam int ACC_W = WEIGHT_W + LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(NSAMP - 1);
    localparam logic [LOG2N-1:0] COUNT_ONE = LOG2N'(1);

    state_t              r_state, w_state_next;
    logic [ACC_W-1:0]    r_acc, w_acc_next;
    logic [LOG2N-1:0]    r_count, w_count_next;
    logic [WEIGHT_W-1:0] r_weight, w_weight_next;
    logic [HEIGHT_W-1:0] r_height, w_height_next;
    logic                r_meas_valid, w_meas_valid_next;
    logic                r_busy, w_busy_next;

    logic                w_in_tol, w_empty, w_settled;
    logic [ACC_W-1:0]    w_sum;
    logic [WEIGHT_W-1:0] w_avg, w_weight_final;

    scale_settle_detector #(
        .TOL        (TOL),
        .SETTLE_CNT (SETTLE_CNT),
        .MIN_LOAD   (MIN_LOAD)
    ) u_settle (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_state        (r_state),
        .i_sample_valid (bus.sample_valid),
        .i_raw          (bus.raw_weight),
        .o_in_tol       (w_in_tol),
        .o_empty        (w_empty),
        .o_settled      (w_settled)
    );

    assign w_sum = r_acc + ACC_W'(bus.raw_weight);
    assign w_avg = WEIGHT_W'(w_sum >> LOG2N);

`ifdef SCALE_TARE_EN
    logic [WEIGHT_W-1:0] r_tare_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tare_off <= '0;
        end else if (r_state == IDLE && bus.sample_valid && bus.tare) begin
            r_tare_off <= bus.raw_weight;
        end
    end

    assign w_weight_final = (w_avg >= r_tare_off) ? (w_avg - r_tare_off) : '0;
`else
    assign w_weight_final = w_avg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.sample_valid && !w_empty) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (bus.sample_valid) begin
                    if (w_empty)        w_state_next = IDLE;
                    else if (w_settled) w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.sample_valid) begin
                    if (w_empty)                  w_state_next = IDLE;
                    else if (!w_in_tol)           w_state_next = SETTLE;
                    else if (r_count == LAST_IDX) w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.meas_ack) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_acc_next        = r_acc;
        w_count_next      = r_count;
        w_weight_next     = r_weight;
        w_height_next     = r_height;
        w_meas_valid_next = (w_state_next == DONE);
        w_busy_next       = (w_state_next == SETTLE) || (w_state_next == ACCUM);
        if (r_state == SETTLE && w_settled) begin
            w_acc_next   = '0;
            w_count_next = '0;
        end else if (r_state == ACCUM && bus.sample_valid && !w_empty && w_in_tol) begin
            w_acc_next   = w_sum;
            w_count_next = r_count + COUNT_ONE;
            // Final accepted sample: average includes it without waiting a cycle.
            if (r_count == LAST_IDX) begin
                w_weight_next = w_weight_final;
                w_height_next = bus.height_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_weight     <= '0;
            r_height     <= '0;
            r_meas_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_acc        <= w_acc_next;
            r_count      <= w_count_next;
            r_weight     <= w_weight_next;
            r_height     <= w_height_next;
            r_meas_valid <= w_meas_valid_next;
            r_busy       <= w_busy_next;
        end
    end

    assign bus.weight     = r_weight;
    assign bus.height     = r_height;
    assign bus.meas_valid = r_meas_valid;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_scale_weight_capture.sv
// Directed bench for scale_weight_capture: settling, averaging, abort paths,
// handshake hold/ack and asynchronous reset.
module tb_scale_weight_capture;
    import scale_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    scale_weight_capture_if bus();

    scale_weight_capture #(
        .NSAMP      (8),
        .TOL        (2),
        .SETTLE_CNT (4),
        .MIN_LOAD   (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int raw, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b1;
            bus.raw_weight   = 9'(raw);
            tick();
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic ack();
        bus.meas_ack = 1'b1;
        tick();
        bus.meas_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (bus.weight !== 9'd0) begin tests_failed++; $display("FAIL reset_weight got=%0d exp=0", bus.weight); end
        tests_run++; if (bus.height !== 8'd0) begin tests_failed++; $display("FAIL reset_height got=%0d exp=0", bus.height); end
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.meas_valid); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset done");
    endtask

    task automatic test_constant();
        bus.height_in = 8'd170;
        send(331, 12);
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL const_early_valid got=%b exp=0", bus.meas_valid); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL const_busy got=%b exp=1", bus.busy); end
        send(331, 1);
        tests_run++; if (bus.weight !== 9'd331) begin tests_failed++; $display("FAIL const_weight got=%0d exp=331", bus.weight); end
        tests_run++; if (bus.height !== 8'd170) begin tests_failed++; $display("FAIL const_height got=%0d exp=170", bus.height); end
        tests_run++; if (bus.meas_valid !== 1'b1) begin tests_failed++; $display("FAIL const_valid got=%b exp=1", bus.meas_valid); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL const_done_busy got=%b exp=0", bus.busy); end
        $display("[TB] constant: weight=%0d height=%0d", bus.weight, bus.height);
    endtask

    task automatic test_handshake();
        bus.height_in = 8'd180;
        for (int i = 0; i < 20; i++) begin
            send(200, 1);
            tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd331 || bus.height !== 8'd170) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d got valid=%b weight=%0d height=%0d exp valid=1 weight=331 height=170",
                         i, bus.meas_valid, bus.weight, bus.height);
            end
        end
        ack();
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL ack_valid got=%b exp=0", bus.meas_valid); end
        tests_run++; if (bus.weight !== 9'd331) begin tests_failed++; $display("FAIL ack_weight_kept got=%0d exp=331", bus.weight); end
        send(200, 13);
        tests_run++; if (bus.weight !== 9'd200) begin tests_failed++; $display("FAIL fresh_weight got=%0d exp=200", bus.weight); end
        tests_run++; if (bus.height !== 8'd180) begin tests_failed++; $display("FAIL fresh_height got=%0d exp=180", bus.height); end
        tests_run++; if (bus.meas_valid !== 1'b1) begin tests_failed++; $display("FAIL fresh_valid got=%b exp=1", bus.meas_valid); end
        $display("[TB] handshake: weight=%0d height=%0d", bus.weight, bus.height);
        ack();
    endtask

    task automatic test_average();
        send(331, 5);
        for (int i = 0; i < 4; i++) begin
            send(330, 1);
            send(332, 1);
        end
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd331) begin
            tests_failed++; $display("FAIL avg_alt got valid=%b weight=%0d exp valid=1 weight=331", bus.meas_valid, bus.weight);
        end
        $display("[TB] average alt: weight=%0d", bus.weight);
        ack();
        send(331, 5);
        send(330, 7);
        send(331, 1);
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd330) begin
            tests_failed++; $display("FAIL avg_floor got valid=%b weight=%0d exp valid=1 weight=330", bus.meas_valid, bus.weight);
        end
        $display("[TB] average floor: weight=%0d", bus.weight);
        ack();
    endtask

    task automatic test_resettle();
        send(331, 8);
        send(340, 1);
        tests_run++; if (bus.busy !== 1'b1 || bus.meas_valid !== 1'b0) begin
            tests_failed++; $display("FAIL resettle_state got busy=%b valid=%b exp busy=1 valid=0", bus.busy, bus.meas_valid);
        end
        send(340, 11);
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL resettle_early got=%b exp=0", bus.meas_valid); end
        send(340, 1);
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd340) begin
            tests_failed++; $display("FAIL resettle_weight got valid=%b weight=%0d exp valid=1 weight=340", bus.meas_valid, bus.weight);
        end
        $display("[TB] resettle: weight=%0d", bus.weight);
        ack();
    endtask

    task automatic test_tolerance();
        send(100, 1);
        send(102, 1);
        send(98, 1);
        send(102, 2);
        send(100, 7);
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL tol_edge_early got=%b exp=0", bus.meas_valid); end
        send(100, 1);
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd100) begin
            tests_failed++; $display("FAIL tol_edge_weight got valid=%b weight=%0d exp valid=1 weight=100", bus.meas_valid, bus.weight);
        end
        $display("[TB] tolerance edge: weight=%0d", bus.weight);
        ack();
        send(100, 1);
        send(103, 12);
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL tol_over_early got=%b exp=0", bus.meas_valid); end
        send(103, 1);
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd103) begin
            tests_failed++; $display("FAIL tol_over_weight got valid=%b weight=%0d exp valid=1 weight=103", bus.meas_valid, bus.weight);
        end
        $display("[TB] tolerance over: weight=%0d", bus.weight);
        ack();
    endtask

    task automatic test_empty();
        send(9, 1);
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL below_min_busy got=%b exp=0", bus.busy); end
        send(10, 1);
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL at_min_busy got=%b exp=1", bus.busy); end
        send(11, 2);
        send(5, 1);
        tests_run++; if (bus.busy !== 1'b0 || bus.meas_valid !== 1'b0) begin
            tests_failed++; $display("FAIL empty_abort got busy=%b valid=%b exp busy=0 valid=0", bus.busy, bus.meas_valid);
        end
        $display("[TB] empty abort: busy=%b", bus.busy);
    endtask

    task automatic test_reset_mid();
        send(150, 8);
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        #2;
        tests_run++; if (bus.weight !== 9'd0) begin tests_failed++; $display("FAIL mid_rst_weight got=%0d exp=0", bus.weight); end
        tests_run++; if (bus.height !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_height got=%0d exp=0", bus.height); end
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got=%b exp=0", bus.meas_valid); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        send(150, 12);
        tests_run++; if (bus.meas_valid !== 1'b0) begin tests_failed++; $display("FAIL post_rst_early got=%b exp=0", bus.meas_valid); end
        send(150, 1);
        tests_run++; if (bus.meas_valid !== 1'b1 || bus.weight !== 9'd150 || bus.height !== 8'd180) begin
            tests_failed++; $display("FAIL post_rst_meas got valid=%b weight=%0d height=%0d exp valid=1 weight=150 height=180",
                                     bus.meas_valid, bus.weight, bus.height);
        end
        $display("[TB] post reset: weight=%0d height=%0d", bus.weight, bus.height);
        ack();
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.raw_weight   = '0;
        bus.height_in    = '0;
        bus.meas_ack     = 1'b0;
`ifdef SCALE_TARE_EN
        bus.tare         = 1'b0;
`endif
        test_reset();
        test_constant();
        test_handshake();
        test_average();
        test_resettle();
        test_tolerance();
        test_empty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
